fft16_core: RTL and testbench
=============================

// Module: fft16_core
// PURPOSE
//  16-point radix-2 DIT FFT stage. Collects 16 serial real FIR samples, computes the
//  complex spectrum in 4 registered stage cycles and presents all 16 bins in parallel
//  with a one-cycle fft_valid pulse. Sits directly upstream of the peak-frequency analyzer.
//  Double buffered: the next frame loads while the current frame computes.
// PARAMETERS
//  DW     16  sample / real / imag width (signed Q8.8)
//  TW     16  twiddle width (signed Q2.14, 16384 = 1.0)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  fir_valid  in   1   fir_d valid this cycle; one sample accepted per high cycle
//  fir_d      in   16  signed Q8.8 real sample; imag part taken as 0
//  fft_valid  out  1   one-cycle pulse: fft_d0..fft_d15 hold a new frame
//  fft_d0..fft_d15 out 32 each  bin k = {real[31:16], imag[15:0]}, natural order
//  busy       out  1   high while a frame is in the 4 compute cycles
// BEHAVIOUR
//  - Reset: fft_valid=0, busy=0, all fft_dk=0, sample count=0, both buffers cleared.
//  - Loader: 4-bit count n; on fir_valid, sample written to load buffer index bitrev(n)
//    (imag=0), n++. Gaps in fir_valid hold n. n wraps 15->0.
//  - Edge E0 accepting sample n=15: complete frame (incl. sample 15) copied into work
//    buffer on the same edge; busy=1 from E0. Load buffer free for next frame immediately.
//  - FSM: IDLE -> CALC (stage s=0..3, one stage per edge E1..E4) -> IDLE.
//    Stage s: 8 butterflies, span 2^s, twiddle index (j mod 2^s)*(8>>s).
//  - E4: stage-3 results registered into fft_d0..fft_d15, fft_valid=1 for exactly the
//    cycle after E4, busy=0 after E4. Latency = 4 cycles from last-sample edge.
//  - fft_dk held until next frame's E4; never changes otherwise.
//  - Frames at 1 sample/cycle take 16 cycles > 4 compute cycles: overlap impossible.
//  - Butterfly: P = B*W; re=(Br*Wr - Bi*Wi)>>>14, im=(Br*Wi + Bi*Wr)>>>14 (33-bit sum,
//    arithmetic shift = floor); A'=A+P, B'=A-P, 16-bit results.
//  - Twiddles W^k, k=0..7 (re,im): (16384,0) (15137,-6270) (11585,-11585) (6270,-15137)
//    (0,-16384) (-6270,-15137) (-11585,-11585) (-15137,-6270).
//  - Reset mid-frame or mid-CALC: everything aborts to reset values; partial frame lost.
// CONFIGURATION
//  FFT_SAT_EN defined: product truncation and A+-P saturate to [-32768, 32767].
//  FFT_SAT_EN undefined: all 16-bit results wrap (two's complement, keep low 16 bits).
// STRUCTURE
//  - Package fft_pkg: DW/TW constants, complex-sample struct/typedef, 8-entry twiddle
//    table, bitrev4 function, FSM state encoding.
//  - Sub-module fft_butterfly (combinational, one complex mult + add/sub, honours
//    FFT_SAT_EN); 8 instances per stage, shared across stages via twiddle mux.
// TESTING
//  - Impulse: x0=256, x1..15=0 -> every bin real=256, imag=0; fft_valid 4 cycles after last
//    sample, width 1.
//  - DC: all 16 samples=256 -> fft_d0=32'h1000_0000, bins 1..15 = 0.
//  - Bin-4 cosine: 256,0,-256,0 repeated -> fft_d4=fft_d12 real=2048 imag=0, others 0.
//  - Overflow: all samples 32767 -> fft_d0 real=32767 with FFT_SAT_EN; real=16'hFFF0 (-16)
//    without; bins 1..15 = 0 either way.
//  - Gapped input: impulse frame with random fir_valid gaps -> same result as impulse;
//    back-to-back frames at 1 sample/cycle -> fft_valid every 16 cycles, no corruption.
//  - Reset after 9 samples and during CALC -> outputs 0, no fft_valid; next full
//    impulse frame yields all-256 bins.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, complex sample type, twiddle table, bit reversal and FSM states
package fft_pkg;
  localparam int DW = 16;
  localparam int TW = 16;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;
  typedef enum logic { IDLE, CALC } state_t;
  localparam logic signed [TW-1:0] TW_RE [8] = '{16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270,
                                                 16'sd0, -16'sd6270, -16'sd11585, -16'sd15137};
  localparam logic signed [TW-1:0] TW_IM [8] = '{16'sd0, -16'sd6270, -16'sd11585, -16'sd15137,
                                                 -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270};
  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction
  function automatic logic [DW-1:0] fit16(input logic signed [32:0] v, input logic sat);
    return !sat ? v[DW-1:0] : v > 33'sd32767 ? 16'h7fff : v < -33'sd32768 ? 16'h8000 : v[DW-1:0];
  endfunction
endpackage

// File: rtl/fft16_core_if.sv
// fft16_core_if: serial sample input and parallel spectrum output bundle
interface fft16_core_if;
  import fft_pkg::*;
  logic                 fir_valid;
  logic signed [DW-1:0] fir_d;
  logic                 fft_valid;
  logic [2*DW-1:0]      fft_d [16];
  logic                 busy;
  modport master (output fir_valid, fir_d, input fft_valid, fft_d, busy);
  modport slave (input fir_valid, fir_d, output fft_valid, fft_d, busy);
endinterface

// File: rtl/fft_butterfly.sv
// fft_butterfly: radix-2 DIT butterfly A+-B*W, wraps or saturates when FFT_SAT_EN is defined
module fft_butterfly
  import fft_pkg::*;
(
  input  cplx_t                a,
  input  cplx_t                b,
  input  logic signed [TW-1:0] wr,
  input  logic signed [TW-1:0] wi,
  output cplx_t                ao,
  output cplx_t                bo
);
`ifdef FFT_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif
  logic signed [31:0] rr, ii, ri, ir;
  logic signed [32:0] pr, pi;
  logic signed [16:0] sr, si, dr, di;
  cplx_t p;
  assign rr = b.re * wr;
  assign ii = b.im * wi;
  assign ri = b.re * wi;
  assign ir = b.im * wr;
  assign pr = (33'(rr) - 33'(ii)) >>> 14;
  assign pi = (33'(ri) + 33'(ir)) >>> 14;
  assign p  = cplx_t'{re: fit16(pr, SAT), im: fit16(pi, SAT)};
  assign sr = 17'(a.re) + 17'(p.re);
  assign si = 17'(a.im) + 17'(p.im);
  assign dr = 17'(a.re) - 17'(p.re);
  assign di = 17'(a.im) - 17'(p.im);
  assign ao = cplx_t'{re: fit16(33'(sr), SAT), im: fit16(33'(si), SAT)};
  assign bo = cplx_t'{re: fit16(33'(dr), SAT), im: fit16(33'(di), SAT)};
endmodule

// File: rtl/fft16_core.sv
// fft16_core: double-buffered 16-point radix-2 DIT FFT, 4 stage cycles per frame (FFT_SAT_EN selects saturation)
module fft16_core
  import fft_pkg::*;
(
  input logic        clk,
  input logic        rst,
  fft16_core_if.slave bus
);
  state_t               state, state_nx;
  logic [1:0]           s, s_nx;
  logic [3:0]           n, msk;
  logic                 last, done;
  logic signed [DW-1:0] lb [16];
  cplx_t                wb [16];
  cplx_t                wb_nx [16];
  cplx_t                bf_ao [8];
  cplx_t                bf_bo [8];
  logic [3:0]           it [8];
  logic [3:0]           ib [8];
  logic [2:0]           tk [8];
  assign last     = bus.fir_valid && n == 4'd15;
  assign done     = state == CALC && s == 2'd3;
  assign msk      = (4'd1 << s) - 4'd1;
  assign bus.busy = state == CALC;
  // pair indices and twiddle index of each butterfly for the current stage
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      it[b] = ((4'(b) & ~msk) << 1) | (4'(b) & msk);
      ib[b] = it[b] | (4'd1 << s);
      tk[b] = 3'((4'(b) & msk) << (2'd3 - s));
    end
  end
  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_bf
      fft_butterfly u_bf (
        .a (wb[it[g]]),
        .b (wb[ib[g]]),
        .wr(TW_RE[tk[g]]),
        .wi(TW_IM[tk[g]]),
        .ao(bf_ao[g]),
        .bo(bf_bo[g])
      );
    end
  endgenerate
  // in-place scatter of the butterfly results
  always_comb begin
    wb_nx = wb;
    for (int b = 0; b < 8; b++) begin
      wb_nx[it[b]] = bf_ao[b];
      wb_nx[ib[b]] = bf_bo[b];
    end
  end
  // a completed frame (re)starts the stage sequence; stage 3 returns to idle
  always_comb begin
    state_nx = last ? CALC : done ? IDLE : state;
    s_nx     = last ? 2'd0 : state == CALC ? s + 2'd1 : s;
  end
  // FSM state and stage counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
    end else begin
      state <= state_nx;
      s     <= s_nx;
    end
  end
  // bit-reversed loader; the final sample bypasses into the work buffer with the rest of the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= '0;
      for (int i = 0; i < 16; i++) lb[i] <= '0;
      for (int i = 0; i < 16; i++) wb[i] <= '0;
    end else begin
      if (bus.fir_valid) begin
        lb[bitrev4(n)] <= bus.fir_d;
        n              <= n + 4'd1;
      end
      for (int i = 0; i < 16; i++)
        wb[i] <= last ? (4'(i) == bitrev4(n) ? cplx_t'{re: bus.fir_d, im: '0} : cplx_t'{re: lb[i], im: '0})
               : state == CALC ? wb_nx[i] : wb[i];
    end
  end
  // final stage lands directly in the held output bins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.fft_valid <= 1'b0;
      for (int i = 0; i < 16; i++) bus.fft_d[i] <= '0;
    end else begin
      bus.fft_valid <= done;
      if (done)
        for (int i = 0; i < 16; i++) bus.fft_d[i] <= wb_nx[i];
    end
  end
endmodule

// File: tb/tb_fft16_core.sv
// tb_fft16_core: directed vector table plus reset, gap and back-to-back sequences
module tb_fft16_core;
  import fft_pkg::*;
  typedef struct {
    string             name;
    logic [15:0][15:0] x;
    logic [15:0][31:0] y;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs [6];
  fft16_core_if bus ();
  fft16_core dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [15:0][15:0] x, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.fir_valid = 1'b0;
        bus.fir_d     = 16'hdead;
      end
      @(negedge clk);
      bus.fir_valid = 1'b1;
      bus.fir_d     = x[i];
    end
    @(negedge clk);
    bus.fir_valid = 1'b0;
  endtask
  task automatic wait_result(input string name);
    int m = 1;
    chk({name, " busy"}, 32'(bus.busy), 32'd1);
    while (m < 12 && bus.fft_valid !== 1'b1) begin
      @(negedge clk);
      m++;
    end
    chk({name, " latency"}, m, 32'd5);
    chk({name, " busy_end"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk({name, " pulse"}, 32'(bus.fft_valid), 32'd0);
  endtask
  task automatic check_bins(input string name, input logic [15:0][31:0] y);
    for (int k = 0; k < 16; k++) chk($sformatf("%s bin%0d", name, k), bus.fft_d[k], y[k]);
  endtask
  initial begin
    int          pulses, t1, t2, hits;
    logic [31:0] d0a, d0b, d5b;
    bus.fir_valid = 1'b0;
    bus.fir_d     = '0;
    for (int v = 0; v < 6; v++) begin
      vecs[v].x = '0;
      vecs[v].y = '0;
    end
    vecs[0].name = "impulse";
    vecs[0].x[0] = 16'd256;
    for (int k = 0; k < 16; k++) vecs[0].y[k] = 32'h0100_0000;
    vecs[1].name = "dc";
    for (int k = 0; k < 16; k++) vecs[1].x[k] = 16'd256;
    vecs[1].y[0] = 32'h1000_0000;
    vecs[2].name = "cos4";
    for (int k = 0; k < 16; k++) vecs[2].x[k] = k % 4 == 0 ? 16'd256 : k % 4 == 2 ? 16'hff00 : 16'd0;
    vecs[2].y[4]  = 32'h0800_0000;
    vecs[2].y[12] = 32'h0800_0000;
    vecs[3].name = "delta8";
    vecs[3].x[8] = 16'd256;
    for (int k = 0; k < 16; k++) vecs[3].y[k] = k % 2 == 0 ? 32'h0100_0000 : 32'hff00_0000;
    vecs[4].name = "delta4";
    vecs[4].x[4] = 16'd256;
    for (int k = 0; k < 16; k++)
      vecs[4].y[k] = k % 4 == 0 ? 32'h0100_0000 : k % 4 == 1 ? 32'h0000_ff00 : k % 4 == 2 ? 32'hff00_0000 : 32'h0000_0100;
    vecs[5].name = "overflow";
    for (int k = 0; k < 16; k++) vecs[5].x[k] = 16'h7fff;
`ifdef FFT_SAT_EN
    vecs[5].y[0] = 32'h7fff_0000;
`else
    vecs[5].y[0] = 32'hfff0_0000;
`endif
    repeat (3) @(negedge clk);
    chk("rst fft_valid", 32'(bus.fft_valid), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst bin0", bus.fft_d[0], 32'd0);
    chk("rst bin15", bus.fft_d[15], 32'd0);
    rst = 1'b0;
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].x, 1'b0);
      wait_result(vecs[v].name);
      check_bins(vecs[v].name, vecs[v].y);
    end
    repeat (5) @(negedge clk);
    chk("hold bin0", bus.fft_d[0], vecs[5].y[0]);
    send(vecs[0].x, 1'b1);
    wait_result("gapped");
    check_bins("gapped", vecs[0].y);
    pulses = 0;
    t1 = -1;
    t2 = -1;
    d0a = '0;
    d0b = '0;
    d5b = '0;
    for (int t = 0; t < 44; t++) begin
      @(negedge clk);
      if (bus.fft_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          t1  = t;
          d0a = bus.fft_d[0];
        end else begin
          t2  = t;
          d0b = bus.fft_d[0];
          d5b = bus.fft_d[5];
        end
      end
      bus.fir_valid = t < 32;
      bus.fir_d     = t < 16 || t == 16 ? 16'd256 : 16'd0;
    end
    chk("b2b pulses", pulses, 32'd2);
    chk("b2b first", t1, 32'd20);
    chk("b2b spacing", t2 - t1, 32'd16);
    chk("b2b dc bin0", d0a, 32'h1000_0000);
    chk("b2b imp bin0", d0b, 32'h0100_0000);
    chk("b2b imp bin5", d5b, 32'h0100_0000);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.fir_valid = 1'b1;
      bus.fir_d     = 16'd256;
    end
    @(negedge clk);
    bus.fir_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst9 bin0", bus.fft_d[0], 32'd0);
    chk("rst9 busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    send(vecs[0].x, 1'b0);
    wait_result("after rst9");
    check_bins("after rst9", vecs[0].y);
    send(vecs[1].x, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.fft_valid !== 1'b0) hits++;
    end
    chk("rstcalc no pulse", hits, 32'd0);
    chk("rstcalc bin0", bus.fft_d[0], 32'd0);
    chk("rstcalc busy", 32'(bus.busy), 32'd0);
    send(vecs[0].x, 1'b0);
    wait_result("after rstcalc");
    check_bins("after rstcalc", vecs[0].y);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
